// File: rtl/non_restoring_divider.sv
// Sequential radix-2 non-restoring divider, one quotient bit per enabled clock.
// Define SIGNED_DIVISION_EN for two's-complement operands (truncating division).
module non_restoring_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clk_en_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  valid_entry_i,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  data_valid_o,
  output logic                  busy_o,
  output logic                  divide_by_zero_o
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, DIVIDE, RESTORE, VALID} state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [CW-1:0]         count_reg;
  logic [DATA_WIDTH:0]   prem_reg;
  logic [DATA_WIDTH-1:0] quot_reg;
  logic [DATA_WIDTH-1:0] dsor_reg;

  logic                  accept;
  logic                  dsor_zero;
  logic [DATA_WIDTH-1:0] dividend_mag;
  logic [DATA_WIDTH-1:0] divisor_mag;
  logic [DATA_WIDTH:0]   prem_shift;
  logic [DATA_WIDTH:0]   prem_step;
  logic [DATA_WIDTH-1:0] quot_step;
  logic [DATA_WIDTH-1:0] rem_mag;
  logic [DATA_WIDTH-1:0] quot_final;
  logic [DATA_WIDTH-1:0] rem_final;

  assign accept    = valid_entry_i & clk_en_i & ((state_reg == IDLE) | (state_reg == VALID));
  assign dsor_zero = (divisor_i == '0);

  always_comb begin
    dividend_mag = dividend_i;
    divisor_mag  = divisor_i;
`ifdef SIGNED_DIVISION_EN
    if (dividend_i[DATA_WIDTH-1]) dividend_mag = -dividend_i;
    if (divisor_i[DATA_WIDTH-1])  divisor_mag  = -divisor_i;
`endif
  end

  // One iteration: shift {P,Q}, then add or subtract depending on the old sign of P.
  always_comb begin
    prem_shift = {prem_reg[DATA_WIDTH-1:0], quot_reg[DATA_WIDTH-1]};
    if (prem_reg[DATA_WIDTH])
      prem_step = prem_shift + {1'b0, dsor_reg};
    else
      prem_step = prem_shift - {1'b0, dsor_reg};
    quot_step = {quot_reg[DATA_WIDTH-2:0], ~prem_step[DATA_WIDTH]};
  end

`ifdef SIGNED_DIVISION_EN
  logic neg_quot_reg;
  logic neg_rem_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      neg_quot_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
    end else if (accept) begin
      neg_quot_reg <= dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1];
      neg_rem_reg  <= dividend_i[DATA_WIDTH-1];
    end
  end
`endif

  // The final remainder is in [0, divisor), so the correction fits in DATA_WIDTH bits.
  always_comb begin
    rem_mag    = prem_reg[DATA_WIDTH-1:0] + (prem_reg[DATA_WIDTH] ? dsor_reg : '0);
    quot_final = quot_reg;
    rem_final  = rem_mag;
`ifdef SIGNED_DIVISION_EN
    if (neg_quot_reg) quot_final = -quot_reg;
    if (neg_rem_reg)  rem_final  = -rem_mag;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state_reg <= IDLE;
    else if (clk_en_i)
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, VALID: begin
        if (accept)
          state_next = dsor_zero ? VALID : DIVIDE;
        else if (state_reg == VALID)
          state_next = IDLE;
      end
      DIVIDE:  if (count_reg == '0) state_next = RESTORE;
      RESTORE: state_next = VALID;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_reg == DIVIDE) | (state_reg == RESTORE);
    data_valid_o = (state_reg == VALID);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_reg        <= '0;
      prem_reg         <= '0;
      quot_reg         <= '0;
      dsor_reg         <= '0;
      quotient_o       <= '0;
      remainder_o      <= '0;
      divide_by_zero_o <= 1'b0;
    end else if (clk_en_i) begin
      if (accept) begin
        count_reg        <= CW'(DATA_WIDTH - 1);
        prem_reg         <= '0;
        quot_reg         <= dividend_mag;
        dsor_reg         <= divisor_mag;
        divide_by_zero_o <= dsor_zero;
        if (dsor_zero) begin
          quotient_o  <= '1;
          remainder_o <= dividend_i;
        end
      end else if (state_reg == DIVIDE) begin
        prem_reg <= prem_step;
        quot_reg <= quot_step;
        if (count_reg != '0)
          count_reg <= count_reg - 1'b1;
      end else if (state_reg == RESTORE) begin
        quotient_o  <= quot_final;
        remainder_o <= rem_final;
      end
    end
  end

endmodule
